// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring-subtract steps,
// then a single sign-fixup cycle that commits HI/LO and pulses done.
module muldiv_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        abort_i,
   input  logic        hi_we_i,
   input  logic        lo_we_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        div0_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, hi_q, lo_q, hi_d, lo_d;
   logic        mul_q, neg_lo_q, neg_hi_q, zero_q, done_q, div0_q;

   logic        sgn, is_div, b_zero;
   logic [31:0] abs_a, abs_b, quo, rem;
   logic [32:0] lhs, addend, sum;
   logic [63:0] prod;

   assign sgn    = ~op_i[0];
   assign is_div = op_i[1];
   assign b_zero = (b_i == 32'd0);
   assign abs_a  = (sgn && a_i[31]) ? (32'd0 - a_i) : a_i;
   assign abs_b  = (sgn && b_i[31]) ? (32'd0 - b_i) : b_i;

   // One 33-bit adder: add multiplicand for multiply, subtract divisor for divide.
   assign lhs    = mul_q ? {1'b0, acc_q[63:32]} : {acc_q[63:32], acc_q[31]};
   assign addend = mul_q ? {1'b0, opnd_q} : ~{1'b0, opnd_q};
   assign sum    = lhs + addend + {32'd0, ~mul_q};

   always_comb begin
      acc_d = acc_q;
      if (mul_q)
         acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
      else
         acc_d = sum[32] ? {lhs[31:0], acc_q[30:0], 1'b0} : {sum[31:0], acc_q[30:0], 1'b1};
   end

   assign prod = neg_lo_q ? (64'd0 - acc_q) : acc_q;
   assign quo  = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
   assign rem  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
   assign hi_d = mul_q ? prod[63:32] : rem;
   assign lo_d = mul_q ? prod[31:0]  : quo;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         acc_q    <= 64'd0;
         opnd_q   <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         mul_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && !abort_i) begin
                  mul_q    <= ~is_div;
                  opnd_q   <= is_div ? abs_b : abs_a;
                  acc_q    <= is_div ? {32'd0, abs_a} : {32'd0, abs_b};
                  neg_lo_q <= sgn & (a_i[31] ^ b_i[31]);
                  neg_hi_q <= sgn & is_div & a_i[31];
                  zero_q   <= is_div & b_zero;
                  cnt_q    <= 5'd31;
                  state_q  <= (is_div && b_zero) ? FIX : RUN;
               end else if (!start_i) begin
                  // MTHI/MTLO only land when no operation is being accepted
                  if (hi_we_i) hi_q <= wdata_i;
                  if (lo_we_i) lo_q <= wdata_i;
               end
            end
            RUN: begin
               if (abort_i) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - 5'd1;
                  if (cnt_q == 5'd0) state_q <= FIX;
               end
            end
            FIX: begin
               state_q <= IDLE;
               if (!abort_i) begin
                  if (!zero_q) begin
                     hi_q <= hi_d;
                     lo_q <= lo_d;
                  end
                  div0_q <= zero_q;
                  done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;
   assign div0_o = div0_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expected results are queued at issue and
// checked by an independent monitor whenever done is seen.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n, start, abort, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, div0;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        d0;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   muldiv_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .abort_i(abort), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
      .busy_o(busy), .done_o(done), .div0_o(div0), .hi_o(hi), .lo_o(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
            chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
            chk("result_div0", {63'd0, div0}, {63'd0, e.d0});
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int exp_busy);
      int cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      chk(name, 64'(cyc), 64'(exp_busy));
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int exp_busy);
      exp_t e;
      e.hi = eh; e.lo = el; e.d0 = ed;
      exp_q.push_back(e);
      issue(o, av, bv);
      wait_idle(name, exp_busy);
   endtask

   task automatic write_hilo(input logic is_hi, input logic [31:0] v);
      @(negedge clk);
      hi_we = is_hi; lo_we = ~is_hi; wdata = v;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_state", {hi, lo}, 64'd0);
      chk("reset_flags", {61'd0, busy, done, div0}, 64'd0);
      rst_n = 1'b1;

      run_op("busy_multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
      run_op("busy_mult_neg",  MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
      run_op("busy_div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
      run_op("busy_divu",      DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33);
      run_op("busy_div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33);
      run_op("busy_div_negb",  DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 33);
      run_op("busy_div_nega",  DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33);
      run_op("busy_mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0, 33);

      write_hilo(1'b1, 32'h11);
      write_hilo(1'b0, 32'h22);
      chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});
      run_op("busy_divu_zero", DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1);
      run_op("busy_multu_clr", MULTU, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0, 33);

      // Abort mid-run: stray start and lo_we while busy must be ignored.
      issue(MULT, 32'd6, 32'd7);
      repeat (4) @(negedge clk);
      start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'hBAD;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      chk("busy_during_run", {63'd0, busy}, 64'd1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, {32'd1, 32'd0});
      repeat (40) @(negedge clk);
      chk("abort_hilo_late", {hi, lo}, {32'd1, 32'd0});

      // start and hi_we together: start wins, HI untouched on the accept edge.
      begin
         exp_t e;
         e.hi = 32'd0; e.lo = 32'd6; e.d0 = 1'b0;
         exp_q.push_back(e);
         @(negedge clk);
         start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0; hi_we = 1'b0;
         chk("start_wins_hi", {32'd0, hi}, 64'd1);
         wait_idle("busy_multu_small", 33);
      end

      // abort in IDLE suppresses a coincident start.
      @(negedge clk);
      start = 1'b1; abort = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", {63'd0, busy}, 64'd0);

      run_op("busy_div_zero", DIV, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd6, 1'b1, 1);

      // Reset in the middle of a divide discards it.
      issue(DIV, 32'd1234, 32'd5);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrun_reset_hilo", {hi, lo}, 64'd0);
      chk("midrun_reset_flags", {61'd0, busy, done, div0}, 64'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run_op("busy_after_reset", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);

      @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
